z88_sram_target: RTL and testbench
==================================

// Module: z88_sram_target
// PURPOSE
//  Memory-side responder for the Z88 async-SRAM-style strobe bus (CE_N/OE_N/WE_N, 19-bit address, 8-bit data).
//  It converts each strobed access into one req/ack transaction on a synchronous memory port of variable latency.
//  It stretches the CPU cycle with bus_wait_n until the transaction completes.
//  It sits between the CPU-side RAM/ROM bus and on-chip block RAM or an external memory controller.
// PARAMETERS
//  AW       19   address width of bus and memory port
//  DW       8    data width
//  TIMEOUT  15   max cycles mem_req may stay high without mem_ack before abort (1..255)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   asynchronous, active-high reset
//  bus_a       in   AW  access address
//  bus_di      in   DW  write data from CPU
//  bus_do      out  DW  read data to CPU
//  bus_ce_n    in   1   chip enable, active low
//  bus_oe_n    in   1   read strobe, active low
//  bus_we_n    in   1   write strobe, active low
//  bus_wait_n  out  1   low = CPU must stall
//  mem_req     out  1   transaction request, held until mem_ack or timeout
//  mem_we      out  1   1 = write, 0 = read; stable while mem_req is high
//  mem_addr    out  AW  latched address; stable while mem_req is high
//  mem_wdata   out  DW  latched write data; stable while mem_req is high
//  mem_ack     in   1   one-cycle completion pulse; only valid while mem_req is high
//  mem_rdata   in   DW  read data; valid in the mem_ack cycle
//  err         out  1   one-cycle pulse on timeout or on an illegal strobe combination
// BEHAVIOUR
//  Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_do=8'hFF, bus_wait_n=1, err=0.
//  start = bus_ce_n==0 && (bus_oe_n==0 || bus_we_n==0).
//  FSM states: IDLE, REQ, HOLD.
//  IDLE:
//   - bus_wait_n = ~start (combinational), so the stall is seen in the same cycle as the strobe.
//   - On start: latch bus_a, bus_di and mem_we=~bus_we_n; then go to REQ.
//   - If bus_oe_n and bus_we_n are both low: treat the access as a write and pulse err.
//  REQ:
//   - mem_req=1, bus_wait_n=0, timeout counter counts up from 0.
//   - On mem_ack: drop mem_req next cycle; for reads, register mem_rdata into bus_do; go to HOLD.
//   - On counter==TIMEOUT with no ack: drop mem_req, set bus_do=8'hFF for reads, pulse err, go to HOLD.
//  HOLD:
//   - bus_wait_n=1, bus_do held stable.
//   - Return to IDLE when bus_ce_n==1 or both strobes are high. Exactly one mem transaction per strobe assertion.
//  Latency: strobe in cycle 0, mem_req high in cycle 1. If mem_ack arrives in cycle k (k>=1), bus_do is valid and
//   bus_wait_n=1 in cycle k+1. Minimum stall is 1 cycle beyond the strobe cycle.
//  Strobe released during REQ: the transaction still completes (memory cannot be aborted).
//   - bus_wait_n stays low until ack/timeout; HOLD then exits to IDLE on the next cycle.
//  mem_ack while mem_req is low: ignored.
//  bus_do only changes on ack, timeout or reset. Writes leave bus_do unchanged.
//  Address or data changes while in REQ or HOLD are ignored; the latched values are used.
//  Reset asserted mid-transaction: immediate return to reset values; any pending ack is ignored afterwards.
//  Timeout counter is 8 bits and cleared on entry to REQ. TIMEOUT=0 is illegal.
// TESTING
//  1 Read, ack after 3 cycles: bus_a=19'h00123, oe_n low, mem_rdata=8'h5A ->
//    mem_req high for cycles 1-3, mem_we=0, bus_wait_n low for cycles 0-3, bus_do=8'h5A and wait_n=1 at cycle 4.
//  2 Write, ack at cycle 1: bus_a=19'h7FFFF, bus_di=8'hC3, we_n low ->
//    mem_we=1, mem_addr=19'h7FFFF, mem_wdata=8'hC3, exactly one req, bus_do unchanged.
//  3 No ack, TIMEOUT=15, read -> mem_req drops after 16 cycles high, err pulses once, bus_do=8'hFF, bus_wait_n=1.
//  4 Strobes held low 10 cycles after an ack -> no second mem_req.
//    Strobes released then reasserted -> a new transaction starts.
//  5 oe_n and we_n low together -> treated as a write, err pulses in cycle 0.
//    Separately: ce_n rises mid-REQ -> req held to ack, state returns to IDLE.
//  6 reset pulsed during REQ -> mem_req=0, bus_wait_n=1 and bus_do=8'hFF immediately, without a clock edge;
//    a late mem_ack produces no bus_do change.

Source files
------------

// File: rtl/z88_sram_target_if.sv
// Z88 strobe bus plus synchronous memory port, bundled for the SRAM target.
// slave = the target's view, master = the CPU/memory environment around it.
interface z88_sram_target_if #(
    parameter int AW = 19,
    parameter int DW = 8
);
    logic [AW-1:0] bus_a;
    logic [DW-1:0] bus_di;
    logic [DW-1:0] bus_do;
    logic          bus_ce_n;
    logic          bus_oe_n;
    logic          bus_we_n;
    logic          bus_wait_n;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          err;

    modport slave (
        input  bus_a, bus_di, bus_ce_n, bus_oe_n, bus_we_n, mem_ack, mem_rdata,
        output bus_do, bus_wait_n, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output bus_a, bus_di, bus_ce_n, bus_oe_n, bus_we_n, mem_ack, mem_rdata,
        input  bus_do, bus_wait_n, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/z88_sram_target.sv
// Turns each Z88 CE/OE/WE strobe into exactly one req/ack memory transaction,
// stalling the CPU via bus_wait_n until the memory answers or times out.
module z88_sram_target #(
    parameter int AW      = 19,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset,
    z88_sram_target_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [7:0] TO   = 8'(TIMEOUT);

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] do_q;
    logic          err_q;
    logic          start;
    logic          both;
    logic          wait_n;

    assign start = ~bus.bus_ce_n & (~bus.bus_oe_n | ~bus.bus_we_n);
    assign both  = ~bus.bus_oe_n & ~bus.bus_we_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            do_q    <= '1;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // both strobes low resolves to a write (we_n low wins)
                        addr_q  <= bus.bus_a;
                        wdata_q <= bus.bus_di;
                        we_q    <= ~bus.bus_we_n;
                        req_q   <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // ack on the last allowed cycle still counts as success
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) do_q <= bus.mem_rdata;
                        state <= HOLD;
                    end else if (cnt == TO) begin
                        req_q <= 1'b0;
                        if (!we_q) do_q <= '1;
                        err_q <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.bus_ce_n || (bus.bus_oe_n && bus.bus_we_n)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the CPU sees it in the strobe cycle.
    always_comb begin
        wait_n = 1'b1;
        case (state)
            IDLE:    wait_n = ~start;
            REQ:     wait_n = 1'b0;
            default: wait_n = 1'b1;
        endcase
        if (reset) wait_n = 1'b1;
    end

    assign bus.bus_wait_n = wait_n;
    assign bus.bus_do     = do_q;
    assign bus.mem_req    = req_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.err        = ~reset & (err_q | ((state == IDLE) & start & both));
endmodule

// File: tb/tb_z88_sram_target.sv
// Bench for z88_sram_target: directed vector table, randomized transactions
// against a transaction-level model, and a mid-transaction reset sequence.
module tb_z88_sram_target;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0] model_do;

    always #5 clk = ~clk;

    z88_sram_target_if #(.AW(19), .DW(8)) bif ();

    z88_sram_target #(.AW(19), .DW(8), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        bit          we;
        bit          both;
        logic [18:0] a;
        logic [7:0]  di;
        logic [7:0]  rd;
        int          lat;      // ack cycle, 0 = never ack
        int          rel;      // cycle to raise ce_n, 0 = hold until done
        int          hold;     // extra cycles strobes stay low after completion
        logic [7:0]  exp_do;
        int          exp_req;
        int          exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int nreq = 0;
        int done = 0;
        int nerr = 0;
        bit latch_ok = 1'b1;
        bit extra = 1'b0;
        logic [7:0] do_done = 8'h00;
        step();
        bif.bus_a    = v.a;
        bif.bus_di   = v.di;
        bif.bus_ce_n = 1'b0;
        bif.bus_we_n = ~(v.we | v.both);
        bif.bus_oe_n = ~(~v.we | v.both);
        @(negedge clk);
        chk({nm, "_wait0"}, 32'(bif.bus_wait_n), 32'd0);
        if (bif.err) nerr++;
        for (int c = 1; c <= 40 && done == 0; c++) begin
            step();
            bif.mem_ack   = (v.lat == c);
            bif.mem_rdata = (v.lat == c) ? v.rd : 8'($urandom);
            bif.bus_a     = 19'($urandom);
            bif.bus_di    = 8'($urandom);
            if (v.rel == c) bif.bus_ce_n = 1'b1;
            @(negedge clk);
            if (bif.mem_req) begin
                nreq++;
                if (bif.mem_addr !== v.a || bif.mem_wdata !== v.di || bif.mem_we !== (v.we | v.both))
                    latch_ok = 1'b0;
            end
            if (bif.err) nerr++;
            if (bif.bus_wait_n) begin
                done = c;
                do_done = bif.bus_do;
            end
        end
        chk({nm, "_done_cycle"}, 32'(done), 32'(v.exp_req + 1));
        chk({nm, "_req_cycles"}, 32'(nreq), 32'(v.exp_req));
        chk({nm, "_latched"}, 32'(latch_ok), 32'd1);
        chk({nm, "_do_done"}, 32'(do_done), 32'(v.exp_do));
        for (int h = 0; h < v.hold; h++) begin
            step();
            bif.mem_ack = 1'b0;
            @(negedge clk);
            if (bif.mem_req) extra = 1'b1;
            if (bif.err) nerr++;
        end
        step();
        bif.mem_ack  = 1'b0;
        bif.bus_ce_n = 1'b1;
        bif.bus_oe_n = 1'b1;
        bif.bus_we_n = 1'b1;
        @(negedge clk);
        if (bif.mem_req) extra = 1'b1;
        if (bif.err) nerr++;
        chk({nm, "_wait_rel"}, 32'(bif.bus_wait_n), 32'd1);
        chk({nm, "_do_rel"}, 32'(bif.bus_do), 32'(v.exp_do));
        chk({nm, "_err_pulses"}, 32'(nerr), 32'(v.exp_err));
        chk({nm, "_no_extra_req"}, 32'(extra), 32'd0);
    endtask

    initial begin
        vec_t v;
        reset         = 1'b1;
        bif.bus_a     = '0;
        bif.bus_di    = '0;
        bif.bus_ce_n  = 1'b1;
        bif.bus_oe_n  = 1'b1;
        bif.bus_we_n  = 1'b1;
        bif.mem_ack   = 1'b0;
        bif.mem_rdata = '0;

        tbl[0] = '{1'b0, 1'b0, 19'h00123, 8'h00, 8'h5A,  3, 0,  0, 8'h5A,  3, 0};
        tbl[1] = '{1'b1, 1'b0, 19'h7FFFF, 8'hC3, 8'h00,  1, 0,  0, 8'h5A,  1, 0};
        tbl[2] = '{1'b0, 1'b0, 19'h00010, 8'h00, 8'h00,  0, 0,  0, 8'hFF, 16, 1};
        tbl[3] = '{1'b0, 1'b0, 19'h00200, 8'h00, 8'hA5,  2, 0, 10, 8'hA5,  2, 0};
        tbl[4] = '{1'b0, 1'b0, 19'h00201, 8'h00, 8'h3C,  1, 0,  0, 8'h3C,  1, 0};
        tbl[5] = '{1'b0, 1'b1, 19'h00042, 8'h77, 8'h11,  2, 0,  0, 8'h3C,  2, 1};
        tbl[6] = '{1'b0, 1'b0, 19'h12345, 8'h00, 8'h99,  5, 2,  0, 8'h99,  5, 0};
        tbl[7] = '{1'b0, 1'b0, 19'h40000, 8'h00, 8'hE1, 16, 0,  0, 8'hE1, 16, 0};
        tbl[8] = '{1'b0, 1'b0, 19'h40001, 8'h00, 8'h22, 17, 0,  0, 8'hFF, 16, 1};
        tbl[9] = '{1'b1, 1'b0, 19'h00000, 8'h5E, 8'h00, 16, 0,  2, 8'hFF, 16, 0};

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(bif.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bif.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bif.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bif.mem_wdata), 32'd0);
        chk("rst_bus_do", 32'(bif.bus_do), 32'hFF);
        chk("rst_wait_n", 32'(bif.bus_wait_n), 32'd1);
        chk("rst_err", 32'(bif.err), 32'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Randomized transactions against a per-transaction outcome model.
        model_do = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            bit acked;
            v.we    = 1'($urandom);
            v.both  = ($urandom % 8) == 0;
            v.a     = 19'($urandom);
            v.di    = 8'($urandom);
            v.rd    = 8'($urandom);
            v.lat   = int'($urandom_range(0, 18));
            v.rel   = (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            v.hold  = int'($urandom_range(0, 3));
            acked   = (v.lat >= 1) && (v.lat <= TIMEOUT + 1);
            v.exp_req = acked ? v.lat : TIMEOUT + 1;
            v.exp_err = (v.both ? 1 : 0) + (acked ? 0 : 1);
            if (!(v.we || v.both)) model_do = acked ? v.rd : 8'hFF;
            v.exp_do = model_do;
            run_txn(v, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a read, then a stray ack afterwards.
        tbl[0] = '{1'b0, 1'b0, 19'h00777, 8'h00, 8'h6D, 2, 0, 0, 8'h6D, 2, 0};
        run_txn(tbl[0], "pre_rst");
        step();
        bif.bus_a    = 19'h01234;
        bif.bus_ce_n = 1'b0;
        bif.bus_oe_n = 1'b0;
        step();
        step();
        #1;
        chk("mid_req_high", 32'(bif.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_mem_req", 32'(bif.mem_req), 32'd0);
        chk("arst_wait_n", 32'(bif.bus_wait_n), 32'd1);
        chk("arst_bus_do", 32'(bif.bus_do), 32'hFF);
        chk("arst_err", 32'(bif.err), 32'd0);
        bif.bus_ce_n = 1'b1;
        bif.bus_oe_n = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        bif.mem_ack   = 1'b1;
        bif.mem_rdata = 8'h00;
        @(negedge clk);
        step();
        bif.mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_bus_do", 32'(bif.bus_do), 32'hFF);
        chk("late_ack_mem_req", 32'(bif.mem_req), 32'd0);
        chk("late_ack_wait_n", 32'(bif.bus_wait_n), 32'd1);

        tbl[1] = '{1'b0, 1'b0, 19'h00055, 8'h00, 8'h42, 2, 0, 0, 8'h42, 2, 0};
        run_txn(tbl[1], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
